// File: rtl/mp_pkg.sv
// Shared encodings for the multiplier-project controller and its write-data mux.
// Latency: none (constants, types and a pure address helper only).
// Backpressure: not applicable.
package mp_pkg;

    // Controller states; the write-data mux decodes these same values
    localparam logic [3:0] ST_INIT     = 4'd0;
    localparam logic [3:0] ST_OP_READ  = 4'd1;
    localparam logic [3:0] ST_OP_WAIT1 = 4'd2;
    localparam logic [3:0] ST_RA_READ  = 4'd3;
    localparam logic [3:0] ST_RB_READ  = 4'd4;
    localparam logic [3:0] ST_OP_WAIT2 = 4'd5;
    localparam logic [3:0] ST_OP_CAL   = 4'd6;
    localparam logic [3:0] ST_SELECT   = 4'd7;
    localparam logic [3:0] ST_RESULT   = 4'd8;

    // Register-file regions (upper nibble of the 8-bit address)
    localparam logic [3:0] REG_DATA = 4'h0;
    localparam logic [3:0] REG_INST = 4'h1;
    localparam logic [3:0] REG_CONT = 4'h2;

    // Opcodes; every other opcode value behaves as NOP
    localparam logic [3:0] OPC_MUL  = 4'h1;
    localparam logic [3:0] OPC_HALT = 4'hF;

    // CONT index 0 is the START register, CONT index 1 the interrupt register
    localparam logic [7:0] START_ADDR = {REG_CONT, 4'h0};
    localparam logic [7:0] INT_ADDR   = 8'h21;

    typedef struct packed {
        logic [3:0] opc;
        logic [3:0] rd;
        logic [3:0] ra;
        logic [3:0] rb;
    } inst_t;

    function automatic logic [7:0] rf_a(input logic [3:0] region, input logic [3:0] idx);
        return {region, idx};
    endfunction

endpackage

// File: rtl/mp_pc.sv
// Instruction index counter with synchronous clear/increment and last-entry flag.
// Latency: pc updates on the clock edge after clr/inc; last is combinational from pc.
// Backpressure: none; clr has priority over inc.
module mp_pc #(
    parameter int PC_W = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            clr,
    input  logic            inc,
    output logic [PC_W-1:0] pc,
    output logic            last
);

    // Counter register: clear wins, otherwise step by one on request
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc <= '0;
        end else if (clr) begin
            pc <= '0;
        end else if (inc) begin
            pc <= pc + PC_W'(1);
        end
    end

    // Final instruction slot: advancing from here ends the run instead of wrapping
    assign last = &pc;

endmodule

// File: rtl/mp_ctrl.sv
// Sequencer: fetch instruction, read Ra/Rb, launch multiplier, write Rd, raise interrupt.
// Latency: START->first read 1 cycle; MUL 6+L cycles; NOP/HALT 2 cycles; RESULT 1 cycle.
// Backpressure: none; host accesses while busy are dropped, multiplier bounded by TIMEOUT.
module mp_ctrl
    import mp_pkg::*;
#(
    parameter int PC_W    = 4,
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        s_sel,
    input  logic        s_wr,
    input  logic [15:0] s_addr,
    input  logic [31:0] s_din,
    input  logic [63:0] rf_rdata,
    input  logic [63:0] mul_result,
    input  logic        mul_done,
    output logic [3:0]  cur_state,
    output logic        rf_rd_en,
    output logic        rf_wr_en,
    output logic [7:0]  rf_addr,
    output logic [63:0] to_Rd,
    output logic        mul_start,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    output logic        busy,
    output logic        abort
);

    localparam int TW = $clog2(TIMEOUT + 1);

    logic [3:0]      state;
    logic [3:0]      nxt;
    inst_t           inst;
    inst_t           rd_inst;
    logic [TW-1:0]   tmo_cnt;
    logic            tmo_hit;
    logic            start_req;
    logic            pc_clr;
    logic            pc_inc;
    logic            pc_last;
    logic [PC_W-1:0] pc;
    logic [3:0]      pc_idx;
    logic            unused_in;

    assign rd_inst   = inst_t'(rf_rdata[15:0]);
    assign pc_idx    = 4'(pc);
    assign start_req = (state == ST_INIT) && s_sel && s_wr &&
                       (s_addr[7:0] == START_ADDR) && s_din[0];
    // tmo_cnt holds the number of OP_CAL cycles already completed
    assign tmo_hit   = (tmo_cnt == TW'(TIMEOUT - 1));
    assign unused_in = ^{s_addr[15:8], s_din[31:1], rf_rdata[63:32]};

    mp_pc #(.PC_W(PC_W)) u_pc (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (pc_clr),
        .inc     (pc_inc),
        .pc      (pc),
        .last    (pc_last)
    );

    // Next-state and pc control; opcode is decoded straight off the read data in OP_WAIT1
    always_comb begin
        nxt    = state;
        pc_clr = 1'b0;
        pc_inc = 1'b0;
        case (state)
            ST_INIT: begin
                if (start_req) begin
                    nxt    = ST_OP_READ;
                    pc_clr = 1'b1;
                end
            end
            ST_OP_READ:  nxt = ST_OP_WAIT1;
            ST_OP_WAIT1: begin
                if (rd_inst.opc == OPC_HALT) begin
                    nxt = ST_RESULT;
                end else if (rd_inst.opc == OPC_MUL) begin
                    nxt = ST_RA_READ;
                end else if (pc_last) begin
                    nxt = ST_RESULT;
                end else begin
                    nxt    = ST_OP_READ;
                    pc_inc = 1'b1;
                end
            end
            ST_RA_READ:  nxt = ST_RB_READ;
            ST_RB_READ:  nxt = ST_OP_WAIT2;
            ST_OP_WAIT2: nxt = ST_OP_CAL;
            ST_OP_CAL: begin
                if (mul_done) begin
                    nxt = ST_SELECT;
                end else if (tmo_hit) begin
                    nxt = ST_RESULT;
                end
            end
            ST_SELECT: begin
                if (pc_last) begin
                    nxt = ST_RESULT;
                end else begin
                    nxt    = ST_OP_READ;
                    pc_inc = 1'b1;
                end
            end
            ST_RESULT: begin
                nxt    = ST_INIT;
                pc_clr = 1'b1;
            end
            default: nxt = ST_INIT;
        endcase
    end

    // State register and OP_CAL cycle counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_INIT;
            tmo_cnt <= '0;
        end else begin
            state   <= nxt;
            tmo_cnt <= (state == ST_OP_CAL) ? tmo_cnt + TW'(1) : '0;
        end
    end

    // Instruction and operand latches; operands are held so Rd may alias Ra/Rb
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            inst  <= '0;
            mul_a <= '0;
            mul_b <= '0;
            to_Rd <= '0;
        end else begin
            if (state == ST_OP_WAIT1) inst <= rd_inst;
            if (state == ST_RB_READ) mul_a <= rf_rdata[31:0];
            if (state == ST_OP_WAIT2) mul_b <= rf_rdata[31:0];
            if ((state == ST_OP_CAL) && mul_done) to_Rd <= mul_result;
        end
    end

    // Sticky abort: set when the multiplier misses its deadline, cleared by START
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            abort <= 1'b0;
        end else if (start_req) begin
            abort <= 1'b0;
        end else if ((state == ST_OP_CAL) && !mul_done && tmo_hit) begin
            abort <= 1'b1;
        end
    end

    // Register-file access decode from the registered state: one access per state, never both
    always_comb begin
        rf_rd_en = 1'b0;
        rf_wr_en = 1'b0;
        rf_addr  = 8'h00;
        case (state)
            ST_OP_READ: begin
                rf_rd_en = 1'b1;
                rf_addr  = rf_a(REG_INST, pc_idx);
            end
            ST_RA_READ: begin
                rf_rd_en = 1'b1;
                rf_addr  = rf_a(REG_DATA, inst.ra);
            end
            ST_RB_READ: begin
                rf_rd_en = 1'b1;
                rf_addr  = rf_a(REG_DATA, inst.rb);
            end
            ST_SELECT: begin
                rf_wr_en = 1'b1;
                rf_addr  = rf_a(REG_DATA, inst.rd);
            end
            ST_RESULT: begin
                rf_wr_en = 1'b1;
                rf_addr  = INT_ADDR;
            end
            default: ;
        endcase
    end

    assign mul_start = (state == ST_OP_CAL) && (tmo_cnt == '0);
    assign busy      = (state != ST_INIT);
    assign cur_state = state;

endmodule

// File: tb/tb_mp_ctrl.sv
// Bench for mp_ctrl: register-file and multiplier environment plus program-level reference.
// Latency: responder returns read data one cycle after rf_rd_en, mul_done L cycles into OP_CAL.
// Backpressure: none; every wait is bounded by a cycle budget.
module tb_mp_ctrl;

    localparam int         TMO      = 255;
    localparam logic [3:0] S_INIT   = 4'd0;
    localparam logic [3:0] S_RB     = 4'd4;
    localparam logic [3:0] S_CAL    = 4'd6;
    localparam logic [3:0] S_RESULT = 4'd8;

    typedef struct packed {
        logic        wr;
        logic [7:0]  addr;
        logic [63:0] dat;
    } ev_t;

    typedef struct {
        logic [15:0] inst0;
        logic [31:0] d1;
        logic [31:0] d2;
        int          lat;
        logic [7:0]  w_addr;
        logic [63:0] w_val;
        logic [31:0] a;
        logic [31:0] b;
        int          cyc;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        s_sel = 1'b0;
    logic        s_wr = 1'b0;
    logic [15:0] s_addr = 16'h0;
    logic [31:0] s_din = 32'h0;
    logic [63:0] rf_rdata = 64'h0;
    logic [63:0] mul_result = 64'h0;
    logic        mul_done = 1'b0;
    logic [3:0]  cur_state;
    logic        rf_rd_en;
    logic        rf_wr_en;
    logic [7:0]  rf_addr;
    logic [63:0] to_Rd;
    logic        mul_start;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic        busy;
    logic        abort;

    logic [15:0] inst_mem [16];
    logic [63:0] data_mem [16];
    ev_t         ev_q[$];
    ev_t         exp_q[$];
    int          run_cyc = 0;
    int          exp_cyc = 0;
    logic        exp_ab = 1'b0;
    int          lat = 1;
    logic        stray = 1'b0;
    int          total = 0;
    int          bad = 0;

    mp_ctrl #(.PC_W(4), .TIMEOUT(TMO)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .s_sel      (s_sel),
        .s_wr       (s_wr),
        .s_addr     (s_addr),
        .s_din      (s_din),
        .rf_rdata   (rf_rdata),
        .mul_result (mul_result),
        .mul_done   (mul_done),
        .cur_state  (cur_state),
        .rf_rd_en   (rf_rd_en),
        .rf_wr_en   (rf_wr_en),
        .rf_addr    (rf_addr),
        .to_Rd      (to_Rd),
        .mul_start  (mul_start),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .busy       (busy),
        .abort      (abort)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic ev_t mk_ev(input logic wr, input logic [7:0] addr, input logic [63:0] dat);
        ev_t e;
        e.wr   = wr;
        e.addr = addr;
        e.dat  = dat;
        return e;
    endfunction

    // Program-level reference: walk the instruction list, producing accesses and cycle cost
    task automatic model_run(input int l);
        logic [63:0] dm [16];
        logic [15:0] ins;
        logic [63:0] prod;
        logic        stop;
        exp_q.delete();
        exp_cyc = 0;
        exp_ab  = 1'b0;
        stop    = 1'b0;
        for (int k = 0; k < 16; k++) dm[k] = data_mem[k];
        for (int p = 0; p < 16 && !stop; p++) begin
            ins = inst_mem[p];
            exp_q.push_back(mk_ev(1'b0, {4'h1, 4'(p)}, 64'd0));
            exp_cyc += 2;
            if (ins[15:12] == 4'hF) begin
                stop = 1'b1;
            end else if (ins[15:12] == 4'h1) begin
                exp_q.push_back(mk_ev(1'b0, {4'h0, ins[7:4]}, 64'd0));
                exp_q.push_back(mk_ev(1'b0, {4'h0, ins[3:0]}, 64'd0));
                if (l == 0) begin
                    exp_cyc += 3 + TMO;
                    exp_ab   = 1'b1;
                    stop     = 1'b1;
                end else begin
                    prod = {32'd0, dm[ins[7:4]][31:0]} * {32'd0, dm[ins[3:0]][31:0]};
                    dm[ins[11:8]] = prod;
                    exp_q.push_back(mk_ev(1'b1, {4'h0, ins[11:8]}, prod));
                    exp_cyc += 4 + l;
                end
            end
        end
        exp_q.push_back(mk_ev(1'b1, 8'h21, 64'd1));
        exp_cyc += 1;
    endtask

    // Environment: register file with one-cycle read latency, multiplier, access monitor
    initial begin
        logic        rd_pend;
        logic [63:0] rd_word;
        logic [63:0] wd;
        int          cal_cnt;
        rd_pend = 1'b0;
        rd_word = 64'd0;
        cal_cnt = 0;
        forever begin
            @(negedge clk);
            rf_rdata = rd_pend ? rd_word : {$urandom, $urandom};
            rd_pend  = 1'b0;
            if (!reset_n) begin
                cal_cnt  = 0;
                mul_done = 1'b0;
            end else begin
                if (busy) run_cyc++;
                if (cur_state == S_CAL) begin
                    cal_cnt++;
                    mul_done = (lat != 0) && (cal_cnt == lat);
                end else begin
                    cal_cnt  = 0;
                    mul_done = stray && (cur_state == S_RB);
                end
                mul_result = (mul_done && cur_state == S_CAL) ?
                             ({32'd0, mul_a} * {32'd0, mul_b}) : {$urandom, $urandom};
                chk("mul_start", mul_start, (cur_state == S_CAL) && (cal_cnt == 1));
                chk("rd_wr_excl", rf_rd_en & rf_wr_en, 0);
                if (rf_rd_en) begin
                    ev_q.push_back(mk_ev(1'b0, rf_addr, 64'd0));
                    rd_pend = 1'b1;
                    if (rf_addr[7:4] == 4'h0) rd_word = data_mem[rf_addr[3:0]];
                    else if (rf_addr[7:4] == 4'h1) rd_word = {$urandom, 16'($urandom), inst_mem[rf_addr[3:0]]};
                    else rd_word = {$urandom, $urandom};
                end
                if (rf_wr_en) begin
                    wd = (cur_state == S_RESULT) ? 64'd1 : to_Rd;
                    ev_q.push_back(mk_ev(1'b1, rf_addr, wd));
                    if (rf_addr[7:4] == 4'h0) data_mem[rf_addr[3:0]] = wd;
                end
            end
        end
    end

    task automatic host_start();
        s_sel  = 1'b1;
        s_wr   = 1'b1;
        s_addr = 16'h0020;
        s_din  = 32'h1;
    endtask

    task automatic host_idle();
        s_sel  = 1'b0;
        s_wr   = 1'b0;
        s_addr = 16'h0;
        s_din  = 32'h0;
    endtask

    task automatic run_prog(input int l, input logic inj);
        lat   = l;
        stray = inj;
        ev_q.delete();
        run_cyc = 0;
        @(negedge clk);
        host_start();
        @(negedge clk);
        host_idle();
        chk("start_rd_en", rf_rd_en, 1);
        chk("start_addr", rf_addr, 8'h10);
        chk("start_abort_clr", abort, 0);
        if (inj) begin
            repeat (3) @(negedge clk);
            if (busy) host_start();
            @(negedge clk);
            host_idle();
        end
        for (int i = 0; i < 4000 && busy; i++) @(negedge clk);
        if (busy) begin
            total++;
            bad++;
            $display("FAIL run_bound: busy=%0d after 4000 cycles, want 0", busy);
        end
        stray = 1'b0;
    endtask

    task automatic check_run(input string tag);
        chk($sformatf("%s n_events", tag), ev_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < ev_q.size(); i++)
            chk($sformatf("%s event%0d", tag, i), ev_q[i], exp_q[i]);
        chk($sformatf("%s cycles", tag), run_cyc, exp_cyc);
        chk($sformatf("%s abort", tag), abort, exp_ab);
    endtask

    initial begin
        vec_t vt [4];
        int   wcnt;
        int   l;
        int   p;
        logic [3:0] op;

        vt[0] = '{16'h1312, 32'd7,          32'd6,          3, 8'h03, 64'd42,                 32'd7,          32'd6,          12};
        vt[1] = '{16'h1111, 32'hFFFF_FFFF,  32'd5,          1, 8'h01, 64'hFFFF_FFFE_0000_0001, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  10};
        vt[2] = '{16'h1A21, 32'h0001_0000,  32'h0003_0000,  5, 8'h0A, 64'h0000_0003_0000_0000, 32'h0003_0000,  32'h0001_0000,  14};
        vt[3] = '{16'h1F12, 32'hFFFF_FFFF,  32'd2,          2, 8'h0F, 64'h0000_0001_FFFF_FFFE, 32'hFFFF_FFFF,  32'd2,          11};

        for (int k = 0; k < 16; k++) begin
            inst_mem[k] = 16'hF000;
            data_mem[k] = {$urandom, $urandom};
        end

        // Reset values
        #1;
        chk("rst cur_state", cur_state, S_INIT);
        chk("rst busy", busy, 0);
        chk("rst rf_en", {rf_rd_en, rf_wr_en, mul_start}, 0);
        chk("rst rf_addr", rf_addr, 0);
        chk("rst to_Rd", to_Rd, 0);
        chk("rst operands", {mul_a, mul_b}, 0);
        chk("rst abort", abort, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // Vector table: one MUL then HALT
        for (int i = 0; i < 4; i++) begin
            inst_mem[0] = vt[i].inst0;
            inst_mem[1] = 16'hF000;
            data_mem[1] = {$urandom, vt[i].d1};
            data_mem[2] = {$urandom, vt[i].d2};
            run_prog(vt[i].lat, 1'b0);
            chk($sformatf("vec%0d n_events", i), ev_q.size(), 6);
            if (ev_q.size() == 6) begin
                chk($sformatf("vec%0d rd_write", i), ev_q[3], mk_ev(1'b1, vt[i].w_addr, vt[i].w_val));
                chk($sformatf("vec%0d irq_write", i), ev_q[5], mk_ev(1'b1, 8'h21, 64'd1));
            end
            chk($sformatf("vec%0d cycles", i), run_cyc, vt[i].cyc);
            chk($sformatf("vec%0d mul_a", i), mul_a, vt[i].a);
            chk($sformatf("vec%0d mul_b", i), mul_b, vt[i].b);
            if (i == 1) chk("self_overwrite", data_mem[1], 64'hFFFF_FFFE_0000_0001);
        end

        // Re-START while busy plus stray mul_done in RB_READ: no effect on the run
        inst_mem[0] = 16'h1312;
        inst_mem[1] = 16'hF000;
        model_run(3);
        run_prog(3, 1'b1);
        check_run("inj");
        repeat (3) @(negedge clk);
        chk("inj no_restart", busy, 0);

        // Multiplier never answers: timeout, abort, no Rd write
        inst_mem[0] = 16'h1312;
        model_run(0);
        run_prog(0, 1'b0);
        check_run("timeout");
        chk("timeout abort_set", abort, 1);

        // All sixteen entries MUL: run ends on the last index without wrapping
        for (int k = 0; k < 16; k++) inst_mem[k] = {4'h1, 12'($urandom)};
        l = int'($urandom_range(1, 4));
        model_run(l);
        run_prog(l, 1'b0);
        check_run("all_mul");
        wcnt = 0;
        foreach (ev_q[i]) if (ev_q[i].wr && ev_q[i].addr[7:4] == 4'h0) wcnt++;
        chk("all_mul rd_writes", wcnt, 16);

        // Random programs mixing MUL, HALT and NOP opcodes
        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < 16; k++) begin
                p = int'($urandom_range(0, 9));
                op = (p < 6) ? 4'h1 : (p == 6) ? 4'hF : 4'(p);
                inst_mem[k] = {op, 12'($urandom)};
                data_mem[k] = {$urandom, $urandom};
            end
            if (r == 2) inst_mem[0][15:12] = 4'h1;
            l = int'($urandom_range(1, 5));
            model_run(l);
            run_prog(l, r == 2);
            check_run($sformatf("rand%0d", r));
        end

        // Reset in the middle of OP_CAL
        inst_mem[0] = 16'h1312;
        lat = 0;
        @(negedge clk);
        host_start();
        @(negedge clk);
        host_idle();
        for (int i = 0; i < 50 && cur_state != S_CAL; i++) @(negedge clk);
        chk("midrst reach_cal", cur_state, S_CAL);
        repeat (10) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("midrst cur_state", cur_state, S_INIT);
        chk("midrst mul_start", mul_start, 0);
        chk("midrst rf_wr_en", rf_wr_en, 0);
        chk("midrst busy", busy, 0);
        chk("midrst abort", abort, 0);
        chk("midrst to_Rd", to_Rd, 0);
        @(negedge clk);
        reset_n = 1'b1;

        // Recovery after reset
        inst_mem[0] = 16'h1523;
        inst_mem[1] = 16'h0000;
        inst_mem[2] = 16'hF000;
        model_run(2);
        run_prog(2, 1'b0);
        check_run("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
